unidade_controle_jogo: RTL and testbench

Moore state machine that sequences the memory-game datapath: clears and advances the round and address counters, loads the player's move into the register, runs the timeout counter while waiting for a move, and reports win, loss or timeout. It connects one-to-one to the datapath control inputs (zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE, zeraT, contaT) and status outputs (jogada_feita, jogada_correta, enderecoIgualRodada, fimCR, timeout).

---
 rtl/unidade_controle_jogo.sv | 135 +++++++++++++
 tb/tb_unidade_controle_jogo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo.sv
// Memory-game control unit: Moore FSM sequencing the datapath (counters, move register, timeout).
// Latency: outputs decode the current state only; each transition takes one clock edge.
// No backpressure: espera_jogada holds until jogada_feita or timeout, final states hold until iniciar.
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimCR,
  input  logic       timeout,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraCR,
  output logic       contaCR,
  output logic       zeraCE,
  output logic       contaCE,
  output logic       zeraT,
  output logic       contaT,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL        = 4'h0;
  localparam logic [3:0] PREPARACAO     = 4'h1;
  localparam logic [3:0] INICIO_RODADA  = 4'h2;
  localparam logic [3:0] ESPERA_JOGADA  = 4'h3;
  localparam logic [3:0] REGISTRA       = 4'h4;
  localparam logic [3:0] COMPARACAO     = 4'h5;
  localparam logic [3:0] PROXIMO        = 4'h6;
  localparam logic [3:0] PROXIMA_RODADA = 4'h7;
  localparam logic [3:0] FIM_ACERTOU    = 4'hC;
  localparam logic [3:0] FIM_ERROU      = 4'hD;
  localparam logic [3:0] FIM_TIMEOUT    = 4'hE;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // State register with synchronous reset back to inicial
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused codes fall back to inicial
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:        if (iniciar) state_d = PREPARACAO;
      PREPARACAO:     state_d = INICIO_RODADA;
      INICIO_RODADA:  state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // timeout has priority over a move arriving in the same cycle
        if (timeout)           state_d = FIM_TIMEOUT;
        else if (jogada_feita) state_d = REGISTRA;
      end
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO: begin
        // register loaded one edge ago, so jogada_correta is valid here
        if (!jogada_correta)          state_d = FIM_ERROU;
        else if (!enderecoIgualRodada) state_d = PROXIMO;
        else if (fimCR)               state_d = FIM_ACERTOU;
        else                          state_d = PROXIMA_RODADA;
      end
      PROXIMO:        state_d = ESPERA_JOGADA;
      PROXIMA_RODADA: state_d = INICIO_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) state_d = PREPARACAO;
      end
      default:        state_d = INICIAL;
    endcase
  end

  // Moore output decode; anything not named for a state stays 0
  always_comb begin
    zeraR      = 1'b0;
    registraR  = 1'b0;
    zeraCR     = 1'b0;
    contaCR    = 1'b0;
    zeraCE     = 1'b0;
    contaCE    = 1'b0;
    zeraT      = 1'b0;
    contaT     = 1'b0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    db_timeout = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraR  = 1'b1;
        zeraCR = 1'b1;
        zeraCE = 1'b1;
        zeraT  = 1'b1;
      end
      INICIO_RODADA: begin
        zeraCE = 1'b1;
        zeraT  = 1'b1;
      end
      ESPERA_JOGADA:  contaT = 1'b1;
      REGISTRA: begin
        registraR = 1'b1;
        zeraT     = 1'b1;
      end
      PROXIMO:        contaCE = 1'b1;
      PROXIMA_RODADA: contaCR = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto     = 1'b1;
        errou      = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  // Debug view of the state code; unused codes are shown as-is for the one cycle they exist
  always_comb begin
    db_estado = state_q;
  end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo with a tiny counter model standing in for the datapath.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada_feita, jogada_correta, timeout;
  logic       enderecoIgualRodada, fimCR;
  logic       zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE, zeraT, contaT;
  logic       pronto, acertou, errou, db_timeout;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  // Expected output vectors: {zeraR,registraR,zeraCR,contaCR,zeraCE,contaCE,zeraT,contaT,
  //                           pronto,acertou,errou,db_timeout,db_estado}
  localparam logic [15:0] V_INI  = 16'h0000;
  localparam logic [15:0] V_PREP = 16'hAA01;
  localparam logic [15:0] V_INIR = 16'h0A02;
  localparam logic [15:0] V_ESP  = 16'h0103;
  localparam logic [15:0] V_REG  = 16'h4204;
  localparam logic [15:0] V_CMP  = 16'h0005;
  localparam logic [15:0] V_PROX = 16'h0406;
  localparam logic [15:0] V_PRXR = 16'h1007;
  localparam logic [15:0] V_ACE  = 16'h00CC;
  localparam logic [15:0] V_ERR  = 16'h00AD;
  localparam logic [15:0] V_TO   = 16'h00BE;
  localparam logic [15:0] V_ILL  = 16'h000A;

  logic [15:0] outs;
  assign outs = {zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE, zeraT, contaT,
                 pronto, acertou, errou, db_timeout, db_estado};

  // Datapath stand-in: round/address counters driven by the DUT controls
  logic [3:0] rod = 4'd0;
  logic [3:0] endr = 4'd0;
  int n_contacr = 0;
  always @(posedge clock) begin
    if (zeraCR) rod <= 4'd0;
    else if (contaCR) rod <= rod + 4'd1;
    if (zeraCE) endr <= 4'd0;
    else if (contaCE) endr <= endr + 4'd1;
    if (contaCR) n_contacr <= n_contacr + 1;
  end
  assign enderecoIgualRodada = (endr == rod);
  assign fimCR = (rod == 4'd15);

  unidade_controle_jogo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
    .fimCR(fimCR), .timeout(timeout),
    .zeraR(zeraR), .registraR(registraR), .zeraCR(zeraCR), .contaCR(contaCR),
    .zeraCE(zeraCE), .contaCE(contaCE), .zeraT(zeraT), .contaT(contaT),
    .pronto(pronto), .acertou(acertou), .errou(errou), .db_timeout(db_timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From inicial or a final state: iniciar pulse, then land in espera_jogada
  task automatic start_game();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
  endtask

  // One move pulse from espera_jogada; leaves the FSM in registra
  task automatic press(input logic ok);
    jogada_feita = 1'b1;
    jogada_correta = ok;
    tick();
    jogada_feita = 1'b0;
  endtask

  // Play round r correctly, ending back in espera_jogada of round r+1 (r < 15)
  task automatic play_round(input int r);
    for (int a = 0; a <= r; a++) begin
      press(1'b1);
      tick();
      tick();
      if (a < r) tick();
      else begin tick(); tick(); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (outs !== V_INI) begin errors++; $display("FAIL reset_state: got %h expected %h", outs, V_INI); end
    tick();
    checks++; if (outs !== V_INI) begin errors++; $display("FAIL idle_hold: got %h expected %h", outs, V_INI); end
  endtask

  task automatic test_start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++; if (outs !== V_PREP) begin errors++; $display("FAIL start_prep: got %h expected %h", outs, V_PREP); end
    tick();
    checks++; if (outs !== V_INIR) begin errors++; $display("FAIL start_inir: got %h expected %h", outs, V_INIR); end
    tick();
    checks++; if (outs !== V_ESP) begin errors++; $display("FAIL start_esp: got %h expected %h", outs, V_ESP); end
    tick();
    checks++; if (outs !== V_ESP) begin errors++; $display("FAIL wait_hold: got %h expected %h", outs, V_ESP); end
  endtask

  task automatic test_full_win();
    int base;
    logic [15:0] exp_v;
    base = n_contacr;
    for (int r = 0; r < 16; r++) begin
      for (int a = 0; a <= r; a++) begin
        press(1'b1);
        checks++; if (outs !== V_REG) begin errors++; $display("FAIL win_reg r%0d a%0d: got %h expected %h", r, a, outs, V_REG); end
        tick();
        checks++; if (outs !== V_CMP) begin errors++; $display("FAIL win_cmp r%0d a%0d: got %h expected %h", r, a, outs, V_CMP); end
        tick();
        exp_v = (a < r) ? V_PROX : ((r < 15) ? V_PRXR : V_ACE);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL win_next r%0d a%0d: got %h expected %h", r, a, outs, exp_v); end
        if (r < 15 || a < r) begin
          if (a < r) tick();
          else begin
            tick();
            checks++; if (outs !== V_INIR) begin errors++; $display("FAIL win_inir r%0d: got %h expected %h", r, outs, V_INIR); end
            tick();
          end
          checks++; if (outs !== V_ESP) begin errors++; $display("FAIL win_esp r%0d a%0d: got %h expected %h", r, a, outs, V_ESP); end
        end
      end
    end
    checks++; if ({pronto, acertou, errou} !== 3'b110) begin errors++; $display("FAIL win_flags: got %b expected 110", {pronto, acertou, errou}); end
    checks++; if (n_contacr - base !== 15) begin errors++; $display("FAIL win_contaCR_count: got %0d expected 15", n_contacr - base); end
    tick();
    checks++; if (outs !== V_ACE) begin errors++; $display("FAIL win_hold: got %h expected %h", outs, V_ACE); end
  endtask

  task automatic test_reset_midgame();
    start_game();
    play_round(0);
    play_round(1);
    play_round(2);
    checks++; if (outs !== V_ESP || rod !== 4'd3) begin errors++; $display("FAIL midgame_setup: got %h rod %0d expected %h rod 3", outs, rod, V_ESP); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (outs !== V_INI) begin errors++; $display("FAIL reset_midgame: got %h expected %h", outs, V_INI); end
  endtask

  task automatic test_wrong_move();
    start_game();
    play_round(0);
    play_round(1);
    press(1'b1); tick(); tick(); tick();
    checks++; if (outs !== V_ESP || endr !== 4'd1) begin errors++; $display("FAIL wrong_setup: got %h addr %0d expected %h addr 1", outs, endr, V_ESP); end
    press(1'b0);
    tick();
    checks++; if (outs !== V_CMP) begin errors++; $display("FAIL wrong_cmp: got %h expected %h", outs, V_CMP); end
    tick();
    checks++; if (outs !== V_ERR) begin errors++; $display("FAIL wrong_err: got %h expected %h", outs, V_ERR); end
    jogada_correta = 1'b1;
    tick();
    checks++; if (outs !== V_ERR) begin errors++; $display("FAIL wrong_hold: got %h expected %h", outs, V_ERR); end
  endtask

  task automatic test_restart();
    iniciar = 1'b1;
    tick();
    checks++; if (outs !== V_PREP) begin errors++; $display("FAIL restart_prep: got %h expected %h", outs, V_PREP); end
    tick();
    checks++; if (outs !== V_INIR) begin errors++; $display("FAIL restart_inir: got %h expected %h", outs, V_INIR); end
    tick();
    checks++; if (outs !== V_ESP) begin errors++; $display("FAIL restart_esp: got %h expected %h", outs, V_ESP); end
    tick();
    checks++; if (outs !== V_ESP) begin errors++; $display("FAIL restart_once: got %h expected %h", outs, V_ESP); end
    iniciar = 1'b0;
  endtask

  task automatic test_timeout();
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    checks++; if (outs !== V_TO) begin errors++; $display("FAIL timeout_state: got %h expected %h", outs, V_TO); end
    start_game();
    checks++; if (outs !== V_ESP) begin errors++; $display("FAIL timeout_restart: got %h expected %h", outs, V_ESP); end
    timeout = 1'b1;
    jogada_feita = 1'b1;
    jogada_correta = 1'b1;
    tick();
    timeout = 1'b0;
    jogada_feita = 1'b0;
    checks++; if (outs !== V_TO) begin errors++; $display("FAIL timeout_priority: got %h expected %h", outs, V_TO); end
  endtask

  task automatic test_illegal();
    force dut.state_q = 4'hA;
    #1;
    checks++; if (outs !== V_ILL) begin errors++; $display("FAIL illegal_outputs: got %h expected %h", outs, V_ILL); end
    release dut.state_q;
    tick();
    checks++; if (outs !== V_INI) begin errors++; $display("FAIL illegal_recover: got %h expected %h", outs, V_INI); end
  endtask

  initial begin
    reset = 1'b0;
    iniciar = 1'b0;
    jogada_feita = 1'b0;
    jogada_correta = 1'b0;
    timeout = 1'b0;
    #2;
    test_reset();
    test_start();
    test_full_win();
    reset = 1'b1; tick(); reset = 1'b0;
    test_reset_midgame();
    test_wrong_move();
    test_restart();
    test_timeout();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
